// File: rtl/dadd_pkg.sv
// Shared types and helpers for the parametrised stochastic scaled adder.
package dadd_pkg;

  typedef enum logic [1:0] {
    SOBOL     = 2'd0,
    SOBOL_ROT = 2'd1,
    LFSR      = 2'd2,
    RR        = 2'd3
  } sel_mode_e;

  // The LFSR must never hold zero; a zero seed is replaced by this value.
  localparam int LFSR_NONZERO_SEED = 32'sd1;

  // Maximal-length Fibonacci tap masks, bit i set means state bit i feeds the XOR.
  function automatic logic [7:0] lfsr_taps(input int w);
    logic [7:0] t;
    case (w)
      32'sd2:  t = 8'b0000_0011;
      32'sd3:  t = 8'b0000_0110;
      32'sd4:  t = 8'b0000_1100;
      32'sd5:  t = 8'b0001_0100;
      32'sd6:  t = 8'b0011_0000;
      32'sd7:  t = 8'b0110_0000;
      32'sd8:  t = 8'b1011_1000;
      default: t = 8'b0000_0011;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/sobol_dim1_gen.sv
// Sobol dimension-1 sequence generator: each advance flips the direction bit
// addressed by the lowest zero bit of the step counter.
module sobol_dim1_gen #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         adv,
  output logic [W-1:0] seq
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt_r;
  logic [W-1:0] seq_r;
  logic [W-1:0] flip_s;

  // Scan from MSB down so the lowest zero bit of the counter wins.
  always_comb begin
    flip_s = {W{1'b0}};
    for (int k = W - 1; k >= 0; k--) begin
      flip_s = cnt_r[k] ? flip_s : (ONE << (W - 1 - k));
    end
  end

  // Sequence and counter state; an all-ones counter closes the period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {W{1'b0}};
      seq_r <= {W{1'b0}};
    end else if (clr) begin
      cnt_r <= {W{1'b0}};
      seq_r <= {W{1'b0}};
    end else if (adv) begin
      if (&cnt_r) begin
        cnt_r <= {W{1'b0}};
        seq_r <= {W{1'b0}};
      end else begin
        cnt_r <= cnt_r + ONE;
        seq_r <= seq_r ^ flip_s;
      end
    end
  end

  assign seq = seq_r;

endmodule

// File: rtl/dadd_rot_param.sv
// Parametrised stochastic scaled adder: forwards one of INUM bitstreams per
// cycle, the index coming from a run-time selectable source.
module dadd_rot_param
  import dadd_pkg::*;
#(
  parameter  int INUM    = 8,
  localparam int LOGINUM = $clog2(INUM)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [INUM-1:0]    in,
  input  logic               cfg_load,
  input  logic [1:0]         cfg_mode,
  input  logic [LOGINUM-1:0] cfg_seed,
  output logic               out,
  output logic               out_vld,
  output logic [LOGINUM-1:0] sel_dbg
);

  localparam logic [LOGINUM-1:0] TAPS    = LOGINUM'(lfsr_taps(LOGINUM));
  localparam logic [LOGINUM-1:0] ONE     = {{(LOGINUM-1){1'b0}}, 1'b1};
  localparam logic [LOGINUM-1:0] NZ_SEED = LOGINUM'(LFSR_NONZERO_SEED);

  sel_mode_e          mode_r;
  logic [LOGINUM-1:0] lfsr_r;
  logic [LOGINUM-1:0] rr_r;
  logic [LOGINUM-1:0] sobol_s;
  logic [LOGINUM-1:0] sel_s;
  logic               lfsr_fb_s;
  logic               sob_adv_s;
  logic               out_r;
  logic               out_vld_r;
  logic [LOGINUM-1:0] sel_dbg_r;

  // Sobol advances every enabled cycle, or only on the LFSR's "1" state when rotated.
  always_comb begin
    lfsr_fb_s = ^(lfsr_r & TAPS);
    case (mode_r)
      SOBOL:     sob_adv_s = en & ~cfg_load;
      SOBOL_ROT: sob_adv_s = en & ~cfg_load & (lfsr_r == ONE);
      default:   sob_adv_s = 1'b0;
    endcase
  end

  sobol_dim1_gen #(.W(LOGINUM)) u_sobol (
    .clk (clk),
    .rst (rst),
    .clr (cfg_load),
    .adv (sob_adv_s),
    .seq (sobol_s)
  );

  // Mode register, LFSR and round-robin counter; cfg_load restarts all sources.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_r <= SOBOL;
      lfsr_r <= ONE;
      rr_r   <= {LOGINUM{1'b0}};
    end else if (cfg_load) begin
      mode_r <= sel_mode_e'(cfg_mode);
      lfsr_r <= (cfg_seed != {LOGINUM{1'b0}}) ? cfg_seed : NZ_SEED;
      rr_r   <= {LOGINUM{1'b0}};
    end else if (en) begin
      lfsr_r <= {lfsr_r[LOGINUM-2:0], lfsr_fb_s};
      rr_r   <= rr_r + ONE;
    end
  end

  // Select mux: pick the index source for the current mode.
  always_comb begin
    case (mode_r)
      SOBOL, SOBOL_ROT: sel_s = sobol_s;
      LFSR:             sel_s = lfsr_r;
      RR:               sel_s = rr_r;
      default:          sel_s = sobol_s;
    endcase
  end

  // Output register: sample the selected stream under en; out/sel_dbg hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_r     <= 1'b0;
      out_vld_r <= 1'b0;
      sel_dbg_r <= {LOGINUM{1'b0}};
    end else if (cfg_load) begin
      out_vld_r <= 1'b0;
    end else if (en) begin
      out_r     <= in[sel_s];
      out_vld_r <= 1'b1;
      sel_dbg_r <= sel_s;
    end else begin
      out_vld_r <= 1'b0;
    end
  end

  assign out     = out_r;
  assign out_vld = out_vld_r;
  assign sel_dbg = sel_dbg_r;

endmodule

// File: tb/tb_dadd_rot_param.sv
// Directed bench for dadd_rot_param with INUM=8, plus a mean check per mode.
module tb_dadd_rot_param;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] in;
  logic       cfg_load;
  logic [1:0] cfg_mode;
  logic [2:0] cfg_seed;
  logic       out;
  logic       out_vld;
  logic [2:0] sel_dbg;

  int n_chk  = 0;
  int n_fail = 0;

  dadd_rot_param #(.INUM(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .in       (in),
    .cfg_load (cfg_load),
    .cfg_mode (cfg_mode),
    .cfg_seed (cfg_seed),
    .out      (out),
    .out_vld  (out_vld),
    .sel_dbg  (sel_dbg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [1:0] m, input logic [2:0] s, input logic e);
    cfg_load = 1'b1; cfg_mode = m; cfg_seed = s; en = e;
    tick();
    cfg_load = 1'b0;
  endtask

  logic [2:0] sob_exp [8];
  logic [2:0] lfsr_exp [8];
  int         thr [8];
  int         ones;
  int         d;
  logic [2:0] rot_exp;

  initial begin
    sob_exp  = '{3'd0, 3'd4, 3'd6, 3'd2, 3'd3, 3'd7, 3'd5, 3'd1};
    lfsr_exp = '{3'd1, 3'd2, 3'd5, 3'd3, 3'd7, 3'd6, 3'd4, 3'd1};
    thr      = '{2, 4, 1, 4, 0, 3, 0, 2};
    rst = 1'b1; en = 1'b0; in = 8'h00; cfg_load = 1'b0; cfg_mode = 2'd0; cfg_seed = 3'd0;
    tick(); tick();
    chk_val("rst_out", {31'd0, out}, 32'd0);
    chk_val("rst_vld", {31'd0, out_vld}, 32'd0);
    chk_val("rst_sel", {29'd0, sel_dbg}, 32'd0);
    rst = 1'b0;

    // T1: Sobol order, only sel 0 picks the single set bit.
    en = 1'b1; in = 8'h01; ones = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_val($sformatf("t1_sel%0d", i), {29'd0, sel_dbg}, {29'd0, sob_exp[i]});
      chk_val($sformatf("t1_vld%0d", i), {31'd0, out_vld}, 32'd1);
      ones += int'(out);
    end
    chk_val("t1_ones", ones, 32'd1);

    // T2: rotated Sobol with seed 3; lfsr hits 1 on the 5th cycle of each 7.
    do_load(2'd1, 3'd3, 1'b1);
    chk_val("t2_load_vld", {31'd0, out_vld}, 32'd0);
    chk_val("t2_load_hold", {29'd0, sel_dbg}, 32'd1);
    in = 8'h10;
    for (int j = 0; j < 21; j++) begin
      tick();
      rot_exp = (j <= 4) ? 3'd0 : (j <= 11) ? 3'd4 : (j <= 18) ? 3'd6 : 3'd2;
      chk_val($sformatf("t2_sel%0d", j), {29'd0, sel_dbg}, {29'd0, rot_exp});
      chk_val($sformatf("t2_out%0d", j), {31'd0, out}, (rot_exp == 3'd4) ? 32'd1 : 32'd0);
    end

    // T3: zero seed becomes 1; LFSR walks all nonzero values.
    do_load(2'd2, 3'd0, 1'b0);
    chk_val("t3_load_vld", {31'd0, out_vld}, 32'd0);
    en = 1'b1;
    for (int j = 0; j < 8; j++) begin
      tick();
      chk_val($sformatf("t3_sel%0d", j), {29'd0, sel_dbg}, {29'd0, lfsr_exp[j]});
    end

    // T4: round robin over 8'hAA, wrapping 7 -> 0.
    do_load(2'd3, 3'd1, 1'b1);
    in = 8'hAA; ones = 0;
    for (int j = 0; j < 16; j++) begin
      tick();
      chk_val($sformatf("t4_sel%0d", j), {29'd0, sel_dbg}, j % 8);
      chk_val($sformatf("t4_out%0d", j), {31'd0, out}, j % 2);
      ones += int'(out);
    end
    chk_val("t4_ones", ones, 32'd8);

    // T5: enable gap holds the select and drops valid for one cycle.
    en = 1'b1; tick();
    chk_val("t5_vld_a", {31'd0, out_vld}, 32'd1);
    chk_val("t5_sel_a", {29'd0, sel_dbg}, 32'd0);
    en = 1'b0; tick();
    chk_val("t5_vld_b", {31'd0, out_vld}, 32'd0);
    chk_val("t5_sel_b", {29'd0, sel_dbg}, 32'd0);
    en = 1'b1; tick();
    chk_val("t5_vld_c", {31'd0, out_vld}, 32'd1);
    chk_val("t5_sel_c", {29'd0, sel_dbg}, 32'd1);
    chk_val("t5_out_c", {31'd0, out}, 32'd1);

    // T6: asynchronous reset mid-stream, then cfg_load together with en.
    for (int j = 0; j < 5; j++) tick();
    rst = 1'b1; #1;
    chk_val("t6_rst_out", {31'd0, out}, 32'd0);
    chk_val("t6_rst_vld", {31'd0, out_vld}, 32'd0);
    chk_val("t6_rst_sel", {29'd0, sel_dbg}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk_val("t6_first_vld", {31'd0, out_vld}, 32'd1);
    chk_val("t6_first_sel", {29'd0, sel_dbg}, 32'd0);
    tick();
    chk_val("t6_second_sel", {29'd0, sel_dbg}, 32'd4);
    do_load(2'd3, 3'd1, 1'b1);
    chk_val("t6_load_vld", {31'd0, out_vld}, 32'd0);
    chk_val("t6_load_hold", {29'd0, sel_dbg}, 32'd4);
    tick();
    chk_val("t6_rr_sel0", {29'd0, sel_dbg}, 32'd0);
    chk_val("t6_rr_vld", {31'd0, out_vld}, 32'd1);
    tick();
    chk_val("t6_rr_sel1", {29'd0, sel_dbg}, 32'd1);

    // Mean check: p = {.5,1,.25,1,0,.75,0,.5}, mean 0.5, equal to the mean of p[1..7].
    for (int m = 0; m < 4; m++) begin
      do_load(m[1:0], 3'd1, 1'b1);
      ones = 0;
      for (int c = 0; c < 16384; c++) begin
        for (int b = 0; b < 8; b++) in[b] = ($urandom_range(0, 3) < thr[b]);
        tick();
        ones += int'(out);
      end
      d = ones - 8192;
      if (d < 0) d = -d;
      chk_val($sformatf("mean_mode%0d", m), (d <= 164) ? 32'd8192 : ones, 32'd8192);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
